// File: rtl/way_read_arbiter.sv
// Round-robin arbiter sharing one way-data read port between NUM_REQ requesters.
// Supports single-word reads and critical-word-first wrapping line bursts with a fixed-latency response.
module way_read_arbiter #(
  parameter int NUM_WAYS     = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int OFFSET_WIDTH = 3,
  parameter int NUM_REQ      = 2,
  parameter int READ_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_burst,
  input  logic [NUM_REQ*NUM_WAYS-1:0]      req_way,
  input  logic [NUM_REQ*OFFSET_WIDTH-1:0]  req_offset,
  output logic                             rd_valid,
  output logic [NUM_WAYS-1:0]              rd_targetWay,
  output logic [OFFSET_WIDTH-1:0]          rd_offset,
  input  logic [DATA_WIDTH-1:0]            rd_dataOut,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic                             rsp_last,
  output logic                             rsp_err
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef logic [ID_W-1:0] id_t;

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_t;

  // Sideband travelling alongside each issued read until its data returns.
  typedef struct packed {
    logic valid;
    id_t  id;
    logic last;
    logic err;
  } rsp_tag_t;

  state_t                  r_state;
  id_t                     r_rr_ptr;
  id_t                     r_bst_id;
  logic [NUM_WAYS-1:0]     r_bst_way;
  logic [OFFSET_WIDTH-1:0] r_bst_start;
  logic [OFFSET_WIDTH-1:0] r_bst_beat;
  logic                    r_bst_err;
  rsp_tag_t                r_pipe [READ_LATENCY];

  logic                    w_grant_found;
  id_t                     w_grant_id;
  id_t                     w_rr_next;
  logic [ID_W:0]           w_cand;
  logic                    w_accept;
  logic [NUM_WAYS-1:0]     w_sel_way;
  logic [OFFSET_WIDTH-1:0] w_sel_off;
  logic                    w_sel_burst;
  logic                    w_sel_bad;
  rsp_tag_t                w_issue;
  rsp_tag_t                w_out;

  // Winner is the first valid requester at or above the rr pointer, wrapping.
  // NOTE: every signal driven from always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_id    = '0;
    w_cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
      if (w_cand >= (ID_W+1)'(NUM_REQ)) begin
        w_cand = w_cand - (ID_W+1)'(NUM_REQ);
      end
      if (!w_grant_found && req_valid[w_cand[ID_W-1:0]]) begin
        w_grant_found = 1'b1;
        w_grant_id    = w_cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    w_sel_way   = '0;
    w_sel_off   = '0;
    w_sel_burst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (id_t'(i) == w_grant_id) begin
        w_sel_way   = req_way[i*NUM_WAYS +: NUM_WAYS];
        w_sel_off   = req_offset[i*OFFSET_WIDTH +: OFFSET_WIDTH];
        w_sel_burst = req_burst[i];
      end
    end
  end

  assign w_sel_bad = !$onehot(w_sel_way);
  assign w_rr_next = (w_grant_id == id_t'(NUM_REQ-1)) ? id_t'(0) : id_t'(w_grant_id + 1'b1);

  // Gating with rst_n keeps the combinational outputs quiet while reset is asserted.
  assign w_accept = rst_n && (r_state == S_IDLE) && w_grant_found;

  always_comb begin
    req_ready = '0;
    if (w_accept) begin
      req_ready[w_grant_id] = 1'b1;
    end
  end

  always_comb begin
    rd_valid     = 1'b0;
    rd_targetWay = '0;
    rd_offset    = '0;
    w_issue      = '0;
    if (rst_n) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            rd_valid     = 1'b1;
            rd_offset    = w_sel_off;
            rd_targetWay = w_sel_bad ? '0 : w_sel_way;
            w_issue      = '{valid: 1'b1, id: w_grant_id, last: !w_sel_burst, err: w_sel_bad};
          end
        end
        S_BURST: begin
          rd_valid     = 1'b1;
          rd_offset    = r_bst_start + r_bst_beat;
          rd_targetWay = r_bst_err ? '0 : r_bst_way;
          w_issue      = '{valid: 1'b1, id: r_bst_id, last: (r_bst_beat == '1), err: r_bst_err};
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_bst_id    <= '0;
      r_bst_way   <= '0;
      r_bst_start <= '0;
      r_bst_beat  <= '0;
      r_bst_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rr_ptr <= w_rr_next;
            if (w_sel_burst) begin
              r_bst_id    <= w_grant_id;
              r_bst_way   <= w_sel_way;
              r_bst_start <= w_sel_off;
              r_bst_err   <= w_sel_bad;
              r_bst_beat  <= OFFSET_WIDTH'(1);
              r_state     <= S_BURST;
            end
          end
        end
        S_BURST: begin
          r_bst_beat <= r_bst_beat + 1'b1;
          if (r_bst_beat == '1) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Response tag pipeline; clearing it on reset is what drops in-flight reads.
  // NOTE: only the valid bits must be reset for correctness; the tag fields are cleared too since it is cheap here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < READ_LATENCY; s++) begin
        r_pipe[s] <= '0;
      end
    end else begin
      r_pipe[0] <= w_issue;
      for (int s = 1; s < READ_LATENCY; s++) begin
        r_pipe[s] <= r_pipe[s-1];
      end
    end
  end

  assign w_out = r_pipe[READ_LATENCY-1];

  always_comb begin
    rsp_valid = '0;
    if (w_out.valid) begin
      rsp_valid[w_out.id] = 1'b1;
    end
  end

  assign rsp_data = (w_out.valid && !w_out.err) ? rd_dataOut : '0;
  assign rsp_last = w_out.valid && w_out.last;
  assign rsp_err  = w_out.valid && w_out.err;

endmodule

// File: tb/tb_way_read_arbiter.sv
// Directed bench for way_read_arbiter: reset, single read, round-robin, wrapping burst, bad way, reset mid-burst.
// A second instance with READ_LATENCY=3 shares the stimulus to check the deeper response pipeline.
module tb_way_read_arbiter;

  localparam int NW = 4;
  localparam int DW = 32;
  localparam int OW = 3;
  localparam int NR = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_burst = '0;
  logic [NR*NW-1:0] req_way = '0;
  logic [NR*OW-1:0] req_offset = '0;
  logic [DW-1:0]    rd_dataOut = '0;

  logic [NR-1:0] req_ready,    req_ready_l3;
  logic          rd_valid,     rd_valid_l3;
  logic [NW-1:0] rd_targetWay, rd_targetWay_l3;
  logic [OW-1:0] rd_offset,    rd_offset_l3;
  logic [NR-1:0] rsp_valid,    rsp_valid_l3;
  logic [DW-1:0] rsp_data,     rsp_data_l3;
  logic          rsp_last,     rsp_last_l3;
  logic          rsp_err,      rsp_err_l3;

  int n_vec = 0;
  int n_err = 0;

  way_read_arbiter #(.NUM_WAYS(NW), .DATA_WIDTH(DW), .OFFSET_WIDTH(OW), .NUM_REQ(NR), .READ_LATENCY(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_burst(req_burst),
    .req_way(req_way), .req_offset(req_offset), .rd_valid(rd_valid), .rd_targetWay(rd_targetWay),
    .rd_offset(rd_offset), .rd_dataOut(rd_dataOut), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .rsp_err(rsp_err)
  );

  way_read_arbiter #(.NUM_WAYS(NW), .DATA_WIDTH(DW), .OFFSET_WIDTH(OW), .NUM_REQ(NR), .READ_LATENCY(3)) u_dut_l3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_l3), .req_burst(req_burst),
    .req_way(req_way), .req_offset(req_offset), .rd_valid(rd_valid_l3), .rd_targetWay(rd_targetWay_l3),
    .rd_offset(rd_offset_l3), .rd_dataOut(rd_dataOut), .rsp_valid(rsp_valid_l3), .rsp_data(rsp_data_l3),
    .rsp_last(rsp_last_l3), .rsp_err(rsp_err_l3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v, input logic b, input logic [NW-1:0] way,
                         input logic [OW-1:0] off);
    req_valid[i]            = v;
    req_burst[i]            = b;
    req_way[i*NW +: NW]     = way;
    req_offset[i*OW +: OW]  = off;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset with requests pending: everything must stay quiet.
    rd_dataOut = 32'hDEAD_BEEF;
    repeat (2) tick();
    set_req(0, 1'b1, 1'b0, 4'b0001, 3'd1);
    set_req(1, 1'b1, 1'b0, 4'b0010, 3'd2);
    mid();
    check("rst_ready",    req_ready, 2'b00);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_way",      rd_targetWay, 4'b0000);
    check("rst_rsp",      rsp_valid, 2'b00);
    check("rst_rsp_l3",   rsp_valid_l3, 2'b00);
    check("rst_data",     rsp_data, 32'h0);

    // Round-robin from pointer 0 with both requesters continuously valid.
    rst_n = 1'b1;
    rd_dataOut = 32'h0;
    #1;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin
        tick();
        mid();
      end
      check("rr_ready", req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
      check("rr_off",   rd_offset, (c % 2 == 0) ? 3'd1 : 3'd2);
      if (c > 0) check("rr_rsp", rsp_valid, (c % 2 == 0) ? 2'b10 : 2'b01);
    end
    tick();
    set_req(0, 1'b0, 1'b0, 4'b0000, 3'd0);
    set_req(1, 1'b0, 1'b0, 4'b0000, 3'd0);
    mid();
    check("rr_rsp_last", rsp_valid, 2'b10);

    // Single read, requester 0.
    tick();
    set_req(0, 1'b1, 1'b0, 4'b0100, 3'd5);
    mid();
    check("sgl_ready",    req_ready, 2'b01);
    check("sgl_rd_valid", rd_valid, 1'b1);
    check("sgl_way",      rd_targetWay, 4'b0100);
    check("sgl_off",      rd_offset, 3'd5);
    check("sgl_rsp0",     rsp_valid, 2'b00);
    tick();
    set_req(0, 1'b0, 1'b0, 4'b0000, 3'd0);
    rd_dataOut = 32'hCAFE_0005;
    mid();
    check("sgl_rsp",      rsp_valid, 2'b01);
    check("sgl_data",     rsp_data, 32'hCAFE_0005);
    check("sgl_last",     rsp_last, 1'b1);
    check("sgl_err",      rsp_err, 1'b0);
    check("sgl_idle",     rd_valid, 1'b0);

    // Wrapping burst from requester 1 (pointer is 1), requester 0 waiting.
    tick();
    set_req(1, 1'b1, 1'b1, 4'b0001, 3'd6);
    set_req(0, 1'b1, 1'b0, 4'b1000, 3'd2);
    mid();
    check("bst_ready0", req_ready, 2'b10);
    check("bst_off0",   rd_offset, 3'd6);
    check("bst_way0",   rd_targetWay, 4'b0001);
    for (int b = 1; b <= 8; b++) begin
      tick();
      if (b == 1) set_req(1, 1'b0, 1'b0, 4'b0000, 3'd0);
      rd_dataOut = 32'h1000_0000 + 32'(b);
      mid();
      if (b < 8) begin
        check("bst_ready", req_ready, 2'b00);
        check("bst_rdv",   rd_valid, 1'b1);
        check("bst_off",   rd_offset, 64'((6 + b) % 8));
        check("bst_way",   rd_targetWay, 4'b0001);
      end else begin
        check("bst_next_ready", req_ready, 2'b01);
        check("bst_next_off",   rd_offset, 3'd2);
        check("bst_next_way",   rd_targetWay, 4'b1000);
      end
      check("bst_rsp",  rsp_valid, 2'b10);
      check("bst_data", rsp_data, 32'h1000_0000 + 32'(b));
      check("bst_last", rsp_last, (b == 8) ? 1'b1 : 1'b0);
    end
    tick();
    set_req(0, 1'b0, 1'b0, 4'b0000, 3'd0);
    rd_dataOut = 32'h0000_2222;
    mid();
    check("bst_after_rsp",  rsp_valid, 2'b01);
    check("bst_after_data", rsp_data, 32'h0000_2222);
    check("bst_after_last", rsp_last, 1'b1);

    // Bad way on a single read; also observed through the latency-3 instance.
    repeat (3) tick();
    tick();
    set_req(0, 1'b1, 1'b0, 4'b0110, 3'd3);
    rd_dataOut = 32'hFFFF_FFFF;
    mid();
    check("bad_ready", req_ready, 2'b01);
    check("bad_rdv",   rd_valid, 1'b1);
    check("bad_way",   rd_targetWay, 4'b0000);
    check("bad_off",   rd_offset, 3'd3);
    for (int d = 1; d <= 3; d++) begin
      tick();
      if (d == 1) set_req(0, 1'b0, 1'b0, 4'b0000, 3'd0);
      mid();
      check("bad_l3_rsp", rsp_valid_l3, (d == 3) ? 2'b01 : 2'b00);
      if (d == 1) begin
        check("bad_rsp",  rsp_valid, 2'b01);
        check("bad_err",  rsp_err, 1'b1);
        check("bad_data", rsp_data, 32'h0);
      end
      if (d == 3) begin
        check("bad_l3_err",  rsp_err_l3, 1'b1);
        check("bad_l3_data", rsp_data_l3, 32'h0);
        check("bad_l3_last", rsp_last_l3, 1'b1);
      end
    end

    // Bad way on a burst: every beat flagged.
    tick();
    set_req(1, 1'b1, 1'b1, 4'b0000, 3'd0);
    mid();
    check("badb_ready", req_ready, 2'b10);
    check("badb_way0",  rd_targetWay, 4'b0000);
    for (int b = 1; b <= 8; b++) begin
      tick();
      if (b == 1) set_req(1, 1'b0, 1'b0, 4'b0000, 3'd0);
      rd_dataOut = 32'hABCD_0000 + 32'(b);
      mid();
      check("badb_err",  rsp_err, 1'b1);
      check("badb_data", rsp_data, 32'h0);
      if (b < 8) begin
        check("badb_way", rd_targetWay, 4'b0000);
        check("badb_off", rd_offset, 64'(b));
      end
    end

    // Reset in the middle of a burst from requester 0 (pointer becomes 1).
    tick();
    set_req(0, 1'b1, 1'b1, 4'b0010, 3'd0);
    mid();
    check("mrst_ready", req_ready, 2'b01);
    tick();
    set_req(0, 1'b0, 1'b0, 4'b0000, 3'd0);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_rdv",    rd_valid, 1'b0);
    check("mrst_way",    rd_targetWay, 4'b0000);
    check("mrst_rsp",    rsp_valid, 2'b00);
    check("mrst_rsp_l3", rsp_valid_l3, 2'b00);
    check("mrst_data",   rsp_data, 32'h0);
    mid();
    rst_n = 1'b1;
    for (int q = 0; q < 4; q++) begin
      tick();
      mid();
      check("post_rdv",    rd_valid, 1'b0);
      check("post_rsp",    rsp_valid, 2'b00);
      check("post_rsp_l3", rsp_valid_l3, 2'b00);
    end
    tick();
    set_req(0, 1'b1, 1'b0, 4'b0001, 3'd0);
    set_req(1, 1'b1, 1'b0, 4'b0001, 3'd0);
    mid();
    check("post_rr_ptr", req_ready, 2'b01);
    tick();
    set_req(0, 1'b0, 1'b0, 4'b0000, 3'd0);
    set_req(1, 1'b0, 1'b0, 4'b0000, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
